// File: rtl/ps2_term_pkg.sv
// Shared types and constants for the PS/2 text terminal write path.
package ps2_term_pkg;
  typedef enum logic [2:0] {INIT_CLR, IDLE, DECODE, WRITE, ROW_CLR} state_t;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] BLANK     = 8'h20;
endpackage

// File: rtl/ps2_scan2ascii.sv
// Set-2 make code to ASCII; each entry holds {unshifted, shifted}, 0 = unmapped.
module ps2_scan2ascii (
  input  logic [7:0] scan,
  input  logic       shift,
  output logic [7:0] ascii
);
  logic [15:0] pair;

  always_comb begin
    pair = 16'h0;
    case (scan)
      8'h1C: pair = "aA";  8'h32: pair = "bB";  8'h21: pair = "cC";  8'h23: pair = "dD";
      8'h24: pair = "eE";  8'h2B: pair = "fF";  8'h34: pair = "gG";  8'h33: pair = "hH";
      8'h43: pair = "iI";  8'h3B: pair = "jJ";  8'h42: pair = "kK";  8'h4B: pair = "lL";
      8'h3A: pair = "mM";  8'h31: pair = "nN";  8'h44: pair = "oO";  8'h4D: pair = "pP";
      8'h15: pair = "qQ";  8'h2D: pair = "rR";  8'h1B: pair = "sS";  8'h2C: pair = "tT";
      8'h3C: pair = "uU";  8'h2A: pair = "vV";  8'h1D: pair = "wW";  8'h22: pair = "xX";
      8'h35: pair = "yY";  8'h1A: pair = "zZ";
      8'h16: pair = "1!";  8'h1E: pair = "2@";  8'h26: pair = "3#";  8'h25: pair = "4$";
      8'h2E: pair = "5%";  8'h36: pair = "6^";  8'h3D: pair = "7&";  8'h3E: pair = "8*";
      8'h46: pair = "9(";  8'h45: pair = "0)";
      8'h29: pair = "  ";  8'h4E: pair = "-_";  8'h55: pair = "=+";  8'h41: pair = ",<";
      8'h49: pair = ".>";  8'h4A: pair = "/?";  8'h4C: pair = ";:";  8'h0E: pair = "`~";
      8'h54: pair = "[{";  8'h5B: pair = "]}";
      8'h52: pair = {8'h27, 8'h22};
      8'h5D: pair = {8'h5C, 8'h7C};
      default: pair = 16'h0;
    endcase
    ascii = shift ? pair[7:0] : pair[15:8];
  end
endmodule

// File: rtl/ps2_text_term_ctrl.sv
// Pops PS/2 scancodes, tracks shift/break, and writes characters and clears
// into the text-mode character RAM addressed {row[4:0], col[6:0]}.
module ps2_text_term_ctrl #(
  parameter int         COLS  = 70,
  parameter int         ROWS  = 30,
  parameter logic [7:0] BLANK = ps2_term_pkg::BLANK
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  ps2_data,
  input  logic        ps2_ready,
  output logic        ps2_nextdata_n,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [4:0]  cur_row,
  output logic [6:0]  cur_col,
  output logic        busy,
  output logic        shift_active,
  output logic [7:0]  key_count
);
  import ps2_term_pkg::*;

  localparam logic [6:0] COL_MAX = 7'(COLS - 1);
  localparam logic [4:0] ROW_MAX = 5'(ROWS - 1);

  state_t      state, state_d;
  logic [7:0]  scan_reg, scan_d;
  logic        brk, brk_d;
  logic [4:0]  clr_row, clr_row_d;
  logic [6:0]  clr_col, clr_col_d;
  logic        clr_done, clr_done_d;
  logic        nd_n_d, wr_en_d, busy_d, shift_d, adv;
  logic [11:0] wr_addr_d;
  logic [7:0]  wr_data_d, kc_d, ascii;
  logic [4:0]  row_d, row_nxt;
  logic [6:0]  col_d;
  logic        is_shift;

  ps2_scan2ascii u_map (.scan(scan_reg), .shift(shift_active), .ascii(ascii));

  assign row_nxt  = (cur_row == ROW_MAX) ? 5'd0 : cur_row + 5'd1;
  assign is_shift = (scan_reg == SC_LSHIFT) || (scan_reg == SC_RSHIFT);

  always_comb begin
    state_d = state;  scan_d = scan_reg;  brk_d = brk;
    clr_row_d = clr_row;  clr_col_d = clr_col;  clr_done_d = clr_done;
    nd_n_d = 1'b1;  wr_en_d = 1'b0;  wr_addr_d = wr_addr;  wr_data_d = wr_data;
    row_d = cur_row;  col_d = cur_col;  busy_d = busy;  shift_d = shift_active;
    kc_d = key_count;  adv = 1'b0;
    unique case (state)
      INIT_CLR:
        if (clr_done) begin
          busy_d = 1'b0;  clr_done_d = 1'b0;  state_d = IDLE;
        end else begin
          wr_en_d = 1'b1;  wr_addr_d = {clr_row, clr_col};  wr_data_d = BLANK;
          if (clr_col == COL_MAX) begin
            clr_col_d = 7'd0;
            if (clr_row == ROW_MAX) begin
              clr_row_d = 5'd0;  clr_done_d = 1'b1;
            end else clr_row_d = clr_row + 5'd1;
          end else clr_col_d = clr_col + 7'd1;
        end
      IDLE:
        if (ps2_ready && !busy) begin
          nd_n_d = 1'b0;  scan_d = ps2_data;  state_d = DECODE;
        end
      DECODE: begin
        state_d = IDLE;
        if (scan_reg == SC_BREAK) brk_d = 1'b1;
        else if (brk) begin
          brk_d = 1'b0;
          if (is_shift) shift_d = 1'b0;
        end
        else if (scan_reg == SC_EXT) begin
          // prefix only; the following make code decodes like a plain one
        end
        else if (is_shift) shift_d = 1'b1;
        else if (scan_reg == SC_ENTER) adv = 1'b1;
        else if (scan_reg == SC_BKSP) begin
          if (cur_col != 7'd0) col_d = cur_col - 7'd1;
          else if (cur_row != 5'd0) begin
            row_d = cur_row - 5'd1;  col_d = COL_MAX;
          end
          if (cur_col != 7'd0 || cur_row != 5'd0) begin
            wr_en_d = 1'b1;  wr_addr_d = {row_d, col_d};  wr_data_d = BLANK;
          end
        end
        else if (ascii != 8'd0) state_d = WRITE;
      end
      WRITE: begin
        wr_en_d = 1'b1;  wr_addr_d = {cur_row, cur_col};  wr_data_d = ascii;
        kc_d = key_count + 8'd1;
        if (cur_col < COL_MAX) begin
          col_d = cur_col + 7'd1;  state_d = IDLE;
        end else adv = 1'b1;
      end
      ROW_CLR:
        if (clr_done) begin
          busy_d = 1'b0;  clr_done_d = 1'b0;  state_d = IDLE;
        end else begin
          wr_en_d = 1'b1;  wr_addr_d = {cur_row, clr_col};  wr_data_d = BLANK;
          if (clr_col == COL_MAX) begin
            clr_col_d = 7'd0;  clr_done_d = 1'b1;
          end else clr_col_d = clr_col + 7'd1;
        end
      default: state_d = INIT_CLR;
    endcase
    // line advance: cursor moves first, then the new row is swept blank
    if (adv) begin
      row_d = row_nxt;  col_d = 7'd0;  busy_d = 1'b1;  clr_col_d = 7'd0;  state_d = ROW_CLR;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= INIT_CLR;  scan_reg <= 8'd0;  brk <= 1'b0;
      clr_row <= 5'd0;  clr_col <= 7'd0;  clr_done <= 1'b0;
      ps2_nextdata_n <= 1'b1;  wr_en <= 1'b0;  wr_addr <= 12'd0;  wr_data <= BLANK;
      cur_row <= 5'd0;  cur_col <= 7'd0;  busy <= 1'b1;  shift_active <= 1'b0;
      key_count <= 8'd0;
    end else begin
      state <= state_d;  scan_reg <= scan_d;  brk <= brk_d;
      clr_row <= clr_row_d;  clr_col <= clr_col_d;  clr_done <= clr_done_d;
      ps2_nextdata_n <= nd_n_d;  wr_en <= wr_en_d;  wr_addr <= wr_addr_d;  wr_data <= wr_data_d;
      cur_row <= row_d;  cur_col <= col_d;  busy <= busy_d;  shift_active <= shift_d;
      key_count <= kc_d;
    end
  end
endmodule

// File: tb/tb_ps2_text_term_ctrl.sv
// Directed bench: key-sequence table plus hand sequences for clears, wrap and reset.
module tb_ps2_text_term_ctrl;
  logic        clk = 1'b0, resetn = 1'b0;
  logic [7:0]  ps2_data = 8'h1C;
  logic        ps2_ready = 1'b1;
  logic        ps2_nextdata_n, wr_en, busy, shift_active;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data, key_count;
  logic [4:0]  cur_row;
  logic [6:0]  cur_col;

  always #5 clk = ~clk;

  ps2_text_term_ctrl dut (
    .clk(clk), .resetn(resetn), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
    .ps2_nextdata_n(ps2_nextdata_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cur_row(cur_row), .cur_col(cur_col), .busy(busy), .shift_active(shift_active),
    .key_count(key_count)
  );

  typedef struct {
    logic [7:0]  scan;
    logic [4:0]  row;
    logic [6:0]  col;
    logic [7:0]  kc;
    logic        sh;
    int          nwr;
    logic [11:0] addr;
    logic [7:0]  data;
  } vec_t;

  int checks = 0, errors = 0;
  logic [11:0] addr_log[$];
  logic [7:0]  data_log[$];
  int pop_total = 0, pop_busy = 0, pop_long = 0;
  logic prev_n = 1'b1;

  always @(negedge clk) begin
    if (wr_en) begin
      addr_log.push_back(wr_addr);
      data_log.push_back(wr_data);
    end
    if (!ps2_nextdata_n) begin
      pop_total++;
      if (busy) pop_busy++;
      if (!prev_n) pop_long++;
    end
    prev_n = ps2_nextdata_n;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_nd_n"}, 32'(ps2_nextdata_n), 32'd1);
    chk({tag, "_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_data"}, 32'(wr_data), 32'h20);
    chk({tag, "_row"}, 32'(cur_row), 32'd0);
    chk({tag, "_col"}, 32'(cur_col), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_shift"}, 32'(shift_active), 32'd0);
    chk({tag, "_kc"}, 32'(key_count), 32'd0);
  endtask

  // Checks writes from log index w0 onward form a blank sweep first..last.
  task automatic chk_clear(input string tag, input int w0, input int n,
                           input logic [11:0] first, input logic [11:0] last);
    int bad = 0;
    chk({tag, "_count"}, 32'(addr_log.size() - w0), 32'(n));
    if (addr_log.size() > w0) begin
      chk({tag, "_first"}, 32'(addr_log[w0]), 32'(first));
      chk({tag, "_last"}, 32'(addr_log[addr_log.size()-1]), 32'(last));
      for (int i = w0; i < addr_log.size(); i++)
        if (data_log[i] != 8'h20 || addr_log[i][6:0] >= 7'd70) bad++;
      chk({tag, "_blank"}, 32'(bad), 32'd0);
    end
  endtask

  task automatic pop_byte(input logic [7:0] b);
    bit got = 1'b0;
    ps2_data = b;
    ps2_ready = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (!ps2_nextdata_n) begin got = 1'b1; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL pop_timeout: got none want pop of %0h", b);
    end
    @(posedge clk);
    #1 ps2_ready = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 500 && busy; i++) @(negedge clk);
    if (busy) begin
      checks++; errors++;
      $display("FAIL settle_timeout: got busy=1 want 0");
    end
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    pop_byte(b);
    settle();
  endtask

  task automatic init_sweep(input string tag);
    int w0 = addr_log.size();
    int last = -10, fall = -20;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (wr_en && wr_addr == 12'hEC5) last = c;
      if (!busy) begin fall = c; break; end
    end
    #1;
    chk({tag, "_busy_fall"}, 32'(fall - last), 32'd1);
    chk_clear(tag, w0, 2100, 12'h000, 12'hEC5);
    chk({tag, "_no_pop_busy"}, 32'(pop_busy), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v[21];
    int w0, p0;
    v[0]  = '{8'h1C, 5'd0, 7'd1, 8'd1, 1'b0, 1,  12'h000, 8'h61};
    v[1]  = '{8'hF0, 5'd0, 7'd1, 8'd1, 1'b0, 0,  12'h000, 8'h00};
    v[2]  = '{8'h1C, 5'd0, 7'd1, 8'd1, 1'b0, 0,  12'h000, 8'h00};
    v[3]  = '{8'h12, 5'd0, 7'd1, 8'd1, 1'b1, 0,  12'h000, 8'h00};
    v[4]  = '{8'h1C, 5'd0, 7'd2, 8'd2, 1'b1, 1,  12'h001, 8'h41};
    v[5]  = '{8'hF0, 5'd0, 7'd2, 8'd2, 1'b1, 0,  12'h000, 8'h00};
    v[6]  = '{8'h1C, 5'd0, 7'd2, 8'd2, 1'b1, 0,  12'h000, 8'h00};
    v[7]  = '{8'hF0, 5'd0, 7'd2, 8'd2, 1'b1, 0,  12'h000, 8'h00};
    v[8]  = '{8'h12, 5'd0, 7'd2, 8'd2, 1'b0, 0,  12'h000, 8'h00};
    v[9]  = '{8'h1C, 5'd0, 7'd3, 8'd3, 1'b0, 1,  12'h002, 8'h61};
    v[10] = '{8'h16, 5'd0, 7'd4, 8'd4, 1'b0, 1,  12'h003, 8'h31};
    v[11] = '{8'h59, 5'd0, 7'd4, 8'd4, 1'b1, 0,  12'h000, 8'h00};
    v[12] = '{8'h16, 5'd0, 7'd5, 8'd5, 1'b1, 1,  12'h004, 8'h21};
    v[13] = '{8'hF0, 5'd0, 7'd5, 8'd5, 1'b1, 0,  12'h000, 8'h00};
    v[14] = '{8'h59, 5'd0, 7'd5, 8'd5, 1'b0, 0,  12'h000, 8'h00};
    v[15] = '{8'h29, 5'd0, 7'd6, 8'd6, 1'b0, 1,  12'h005, 8'h20};
    v[16] = '{8'hE0, 5'd0, 7'd6, 8'd6, 1'b0, 0,  12'h000, 8'h00};
    v[17] = '{8'h76, 5'd0, 7'd6, 8'd6, 1'b0, 0,  12'h000, 8'h00};
    v[18] = '{8'h66, 5'd0, 7'd5, 8'd6, 1'b0, 1,  12'h005, 8'h20};
    v[19] = '{8'h4A, 5'd0, 7'd6, 8'd7, 1'b0, 1,  12'h005, 8'h2F};
    v[20] = '{8'h5A, 5'd1, 7'd0, 8'd7, 1'b0, 70, 12'h0C5, 8'h20};

    // power-on: FIFO already holds a key, which must wait out the sweep
    #12 chk_reset("por");
    @(negedge clk);
    resetn = 1'b1;
    init_sweep("init");

    for (int i = 0; i < 21; i++) begin
      w0 = addr_log.size();
      p0 = pop_total;
      send(v[i].scan);
      chk($sformatf("v%0d_writes", i), 32'(addr_log.size() - w0), 32'(v[i].nwr));
      chk($sformatf("v%0d_pops", i), 32'(pop_total - p0), 32'd1);
      if (v[i].nwr > 0 && addr_log.size() > w0) begin
        chk($sformatf("v%0d_addr", i), 32'(addr_log[addr_log.size()-1]), 32'(v[i].addr));
        chk($sformatf("v%0d_data", i), 32'(data_log[data_log.size()-1]), 32'(v[i].data));
      end
      chk($sformatf("v%0d_row", i), 32'(cur_row), 32'(v[i].row));
      chk($sformatf("v%0d_col", i), 32'(cur_col), 32'(v[i].col));
      chk($sformatf("v%0d_kc", i), 32'(key_count), 32'(v[i].kc));
      chk($sformatf("v%0d_shift", i), 32'(shift_active), 32'(v[i].sh));
    end

    // backspace from (1,0) lands on the last column of row 0
    w0 = addr_log.size();
    send(8'h66);
    chk("bs_wrap_writes", 32'(addr_log.size() - w0), 32'd1);
    if (addr_log.size() > w0) begin
      chk("bs_wrap_addr", 32'(addr_log[w0]), 32'h045);
      chk("bs_wrap_data", 32'(data_log[w0]), 32'h20);
    end
    chk("bs_wrap_row", 32'(cur_row), 32'd0);
    chk("bs_wrap_col", 32'(cur_col), 32'd69);

    // character in the last column wraps and clears the next row
    w0 = addr_log.size();
    send(8'h1C);
    if (addr_log.size() > w0) begin
      chk("colwrap_char_addr", 32'(addr_log[w0]), 32'h045);
      chk("colwrap_char_data", 32'(data_log[w0]), 32'h61);
    end
    chk_clear("colwrap_clr", w0 + 1, 70, 12'h080, 12'h0C5);
    chk("colwrap_row", 32'(cur_row), 32'd1);
    chk("colwrap_col", 32'(cur_col), 32'd0);
    chk("colwrap_kc", 32'(key_count), 32'd8);

    // walk to (29,5), then Enter wraps to row 0
    for (int i = 0; i < 28; i++) send(8'h5A);
    for (int i = 0; i < 5; i++) send(8'h1C);
    chk("r29_row", 32'(cur_row), 32'd29);
    chk("r29_col", 32'(cur_col), 32'd5);
    chk("r29_kc", 32'(key_count), 32'd13);
    w0 = addr_log.size();
    send(8'h5A);
    chk("rowwrap_row", 32'(cur_row), 32'd0);
    chk("rowwrap_col", 32'(cur_col), 32'd0);
    chk_clear("rowwrap_clr", w0, 70, 12'h000, 12'h045);

    // backspace at the origin does nothing
    w0 = addr_log.size();
    send(8'h66);
    chk("bs_origin_writes", 32'(addr_log.size() - w0), 32'd0);
    chk("bs_origin_row", 32'(cur_row), 32'd0);
    chk("bs_origin_col", 32'(cur_col), 32'd0);

    // 243 more characters: key_count wraps 255 -> 0
    for (int i = 0; i < 243; i++) send(8'h1C);
    chk("kcwrap_kc", 32'(key_count), 32'd0);
    chk("kcwrap_row", 32'(cur_row), 32'd3);
    chk("kcwrap_col", 32'(cur_col), 32'd33);
    chk("kcwrap_last_addr", 32'(addr_log[addr_log.size()-1]), 32'h1A0);

    // reset in the middle of a row clear
    pop_byte(8'h5A);
    repeat (10) @(negedge clk);
    chk("midclr_busy_before", 32'(busy), 32'd1);
    #2 resetn = 1'b0;
    #1 chk_reset("midclr");
    @(negedge clk);
    resetn = 1'b1;
    init_sweep("reinit");

    chk("pop_width", 32'(pop_long), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
